sub_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that performs a WIDTH-bit unsigned subtraction A - B - bin by reusing one 4-bit ripple-borrow subtractor slice per cycle.
- The borrow is chained across cycles through a register.
- Sits between a valid/ready producer and consumer, giving wide subtraction at 4-bit slice area cost.

---
 rtl/sub_seq_pkg.sv | 21 ++
 rtl/sub_seq_ctrl_slice.sv | 21 ++
 rtl/sub_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_sub_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared types and sizing helpers for the slice-serial subtractor sequencer.
package sub_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

    // Index counter needs at least one bit even for a single slice.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/sub_seq_ctrl_slice.sv
// sub_slice4: combinational 4-bit ripple-borrow subtractor, d = x - y - c.
module sub_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c,
    output logic [3:0] d,
    output logic       bo
);

    logic [4:0] chain_s;

    assign chain_s[0] = c;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign d[i]           = x[i] ^ y[i] ^ chain_s[i];
        assign chain_s[i + 1] = (~x[i] & y[i]) | ((~x[i] | y[i]) & chain_s[i]);
    end

    assign bo = chain_s[4];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Slice-serial WIDTH-bit subtractor (A - B - bin), one 4-bit slice per cycle.
// Optional macro SUB_SEQ_SAT_EN: saturate diff to zero when the result underflows.
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NSLICE = slice_count(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int IDX_W = idx_width(NSLICE);

    state_t             state_r;
    state_t             state_nx_s;
    logic [IDX_W-1:0]   idx_r;
    logic               borrow_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               accept_s;
    logic               last_s;
    logic [SLICE_W-1:0] slice_d_s;
    logic               slice_bo_s;

    sub_slice4 u_slice (
        .x  (a_r[SLICE_W*idx_r +: SLICE_W]),
        .y  (b_r[SLICE_W*idx_r +: SLICE_W]),
        .c  (borrow_r),
        .d  (slice_d_s),
        .bo (slice_bo_s)
    );

    assign last_s = (idx_r == IDX_W'(NSLICE - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and operand acceptance.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand capture, per-slice result write-back and borrow chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            bout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r      <= a;
                        b_r      <= b;
                        borrow_r <= bin;
                        idx_r    <= {IDX_W{1'b0}};
                        diff_r   <= {WIDTH{1'b0}};
                        bout_r   <= 1'b0;
                    end
                end
                RUN: begin
                    diff_r[SLICE_W*idx_r +: SLICE_W] <= slice_d_s;
                    borrow_r                         <= slice_bo_s;
                    if (last_s) begin
                        // idx parks on the last slice so it never leaves range.
                        bout_r <= slice_bo_s;
`ifdef SUB_SEQ_SAT_EN
                        if (slice_bo_s) begin
                            diff_r <= {WIDTH{1'b0}};
                        end
`endif
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    bout_r <= bout_r;
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Handshake flags registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign diff      = diff_r;
    assign bout      = bout_r;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (WIDTH=16): vector table plus handshake corner cases.
module tb_sub_seq_ctrl;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         bin       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    sub_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Issue one operation; hold = cycles of backpressure, early = out_ready high from accept,
    // poke = keep in_valid high with junk operands while the block is busy.
    task automatic issue(input vec_t v, input bit early, input int hold, input bit poke);
        exp_t e;
        exp_t got;
        int   lat;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        bin       = v.bin;
        out_ready = early;
        @(posedge clk);
        #1;
        e.d  = v.d;
        e.bo = v.bo;
`ifdef SUB_SEQ_SAT_EN
        if (v.bo) e.d = '0;
`endif
        sb_q.push_back(e);
        in_valid = poke;
        a        = 16'hFFFF;
        b        = W'($urandom);
        bin      = ~v.bin;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            if (poke) chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'd5);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout out_valid=0 expected=1");
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            got = sb_q.pop_front();
            chk("diff", 32'(diff), 32'(got.d));
            chk("bout", 32'(bout), 32'(got.bo));
            chk("busy_done", 32'(busy), 32'd1);
            chk("in_ready_done", 32'(in_ready), 32'd0);
            if (!early) begin
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_diff", 32'(diff), 32'(got.d));
                    chk("hold_bout", 32'(bout), 32'(got.bo));
                end
                out_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        int stray;
        vec_t v;
        tbl[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
        tbl[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        tbl[2]  = '{16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0};
        tbl[3]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
        tbl[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[5]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
        tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        tbl[7]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0};
        tbl[8]  = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0};
        tbl[9]  = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1};
        tbl[10] = '{16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) issue(tbl[i], 1'b0, 0, 1'b0);

        issue(tbl[1], 1'b0, 10, 1'b0);
        issue(tbl[0], 1'b0, 0, 1'b1);
        issue(tbl[3], 1'b1, 0, 1'b0);

        // Abort in the second RUN cycle; slice 0 of FFFF-0000 is already written.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0000;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("partial_diff", 32'(diff), 32'h000F);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("no_stray_valid", 32'(stray), 32'd0);

        v = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
        issue(v, 1'b0, 0, 1'b0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
